// File: rtl/pdm_cic_decimator.sv
// 4th-order CIC decimator: 1-bit PDM from a MEMS mic -> signed PCM, one sample per 2^DEC_LOG2 mclk ticks.
// Latency: valid_o two clk cycles after the wrapping tick; no backpressure, and pcm_o holds between strobes.
module pdm_cic_decimator #(
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mclk,
    input  logic                    pdm_i,
    output logic signed [OUT_W-1:0] pcm_o,
    output logic                    valid_o
);
    localparam int ACC_W = 4*DEC_LOG2 + 2;
    localparam int SHIFT = 4*DEC_LOG2 - (OUT_W-1);

    localparam logic [DEC_LOG2-1:0]     DCNT_MAX = '1;
    localparam logic signed [ACC_W-1:0] X_POS    = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] X_NEG    = '1;
    localparam logic signed [ACC_W-1:0] Y_MAX    = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    logic                    sync1_q, pdm_s_q, mclk_q;
    logic signed [ACC_W-1:0] i1_q, i2_q, i3_q, i4_q;
    logic signed [ACC_W-1:0] d1_q, d2_q, d3_q, d4_q;
    logic [DEC_LOG2-1:0]     dcnt_q;
    logic                    dec_stb_q;
    logic signed [OUT_W-1:0] pcm_q;
    logic                    valid_q;

    logic                    tick;
    logic signed [ACC_W-1:0] x, c1, c2, c3, c4, y;
    logic signed [OUT_W-1:0] pcm_d;

    assign tick = mclk & ~mclk_q & en;
    assign x    = pdm_s_q ? X_POS : X_NEG;

    // Combs are only meaningful while dec_stb_q is high; the integrators cannot move in
    // that cycle because mclk is at least two clk cycles long.
    assign c1 = i4_q - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;
    assign c4 = c3 - d4_q;
    assign y  = c4 >>> SHIFT;

    // Only +full scale overshoots by one LSB; -full scale lands exactly on the minimum.
    assign pcm_d = (y > Y_MAX) ? Y_MAX[OUT_W-1:0] : y[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            pdm_s_q   <= 1'b0;
            mclk_q    <= 1'b0;
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            i4_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            d4_q      <= '0;
            dcnt_q    <= '0;
            dec_stb_q <= 1'b0;
            pcm_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= pdm_i;
            pdm_s_q   <= sync1_q;
            mclk_q    <= mclk;
            dec_stb_q <= tick && (dcnt_q == DCNT_MAX);
            valid_q   <= dec_stb_q;
            if (tick) begin
                i1_q   <= i1_q + x;
                i2_q   <= i2_q + i1_q;
                i3_q   <= i3_q + i2_q;
                i4_q   <= i4_q + i3_q;
                dcnt_q <= dcnt_q + DEC_LOG2'(1);
            end
            if (dec_stb_q) begin
                d1_q  <= i4_q;
                d2_q  <= c1;
                d3_q  <= c2;
                d4_q  <= c3;
                pcm_q <= pcm_d;
            end
        end
    end

    assign pcm_o   = pcm_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: steady-state PCM values, strobe timing, enable gap, reset, min mclk period.
module tb_pdm_cic_decimator;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               mclk = 1'b0;
    logic               pdm_i = 1'b0;
    logic signed [15:0] pcm_o;
    logic               valid_o;

    pdm_cic_decimator dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mclk    (mclk),
        .pdm_i   (pdm_i),
        .pcm_o   (pcm_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Stimulus pattern and mclk divider controls (written at posedge+1 only)
    int       mdiv    = 8;
    logic [3:0] pat   = 4'b1111;
    int       pat_len = 1;

    // Driver / timing model state (negedge process only)
    int       negcnt = 0;
    int       div    = 0;
    int       pidx   = 0;
    logic     mq     = 1'b0;
    int       tcnt   = 0;
    longint   exp_neg = -1;
    int       vcnt   = 0;
    longint   vlast  = 0;
    longint   vprev  = 0;
    logic signed [15:0] pcm_last = '0;

    always @(negedge clk) begin
        logic m;
        logic exp_now;
        logic tick;
        negcnt++;
        exp_now = (exp_neg == negcnt);
        if (valid_o || exp_now) chk("valid_timing", valid_o, exp_now);
        if (valid_o) begin
            vcnt++;
            pcm_last = pcm_o;
            vprev    = vlast;
            vlast    = negcnt;
        end
        if (exp_now) exp_neg = -1;

        if (rst) begin
            div     = 0;
            m       = 1'b0;
            tick    = 1'b0;
            tcnt    = 0;
            exp_neg = -1;
            mq      = 1'b0;
        end else begin
            div  = (div + 1) % mdiv;
            m    = (div >= mdiv/2);
            tick = m && !mq && en;
            mq   = m;
        end
        if (mclk && !m) pidx = (pidx + 1) % pat_len;
        mclk  = m;
        pdm_i = pat[pidx];
        if (tick) begin
            if (tcnt == 63) exp_neg = negcnt + 2;
            tcnt = (tcnt + 1) % 64;
        end
    end

    task automatic wait_valids(input int n, input int budget);
        int tgt;
        int k;
        tgt = vcnt + n;
        k   = 0;
        while (vcnt < tgt && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (vcnt < tgt) chk("timeout", vcnt, tgt);
    endtask

    task automatic apply_reset(input int new_div, input logic [3:0] new_pat, input int new_len);
        @(posedge clk); #1;
        rst     = 1'b1;
        mdiv    = new_div;
        pat     = new_pat;
        pat_len = new_len;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     v0;
        logic signed [15:0] p0;
        int     k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pcm", pcm_o, 0);
        chk("reset_valid", valid_o, 0);
        rst = 1'b0;
        en  = 1'b1;

        // All ones: saturates, strobes 512 clk apart
        wait_valids(6, 6*512 + 200);
        chk("ones_pcm", pcm_last, 32767);
        chk("ones_rate", vlast - vprev, 512);

        // Enable gap mid-frame
        k = 0;
        while (tcnt != 20 && k < 1000) begin @(posedge clk); k++; end
        #1;
        chk("gap_sync", tcnt, 20);
        en = 1'b0;
        v0 = vcnt;
        p0 = pcm_o;
        repeat (1000) @(posedge clk);
        #1;
        chk("gap_pcm_hold", pcm_o, p0);
        chk("gap_no_valid", vcnt, v0);
        en = 1'b1;
        wait_valids(1, 44*8 + 50);
        chk("gap_resume_pcm", pcm_last, 32767);

        // All zeros: exact negative full scale
        apply_reset(8, 4'b0000, 1);
        wait_valids(6, 6*512 + 200);
        chk("zeros_pcm", pcm_last, -32768);

        // Alternating 1,0: zero mean
        apply_reset(8, 4'b0001, 2);
        wait_valids(6, 6*512 + 200);
        chk("alt_pcm", pcm_last, 0);
        wait_valids(1, 600);
        chk("alt_pcm_next", pcm_last, 0);

        // Repeating 1,1,1,0 (bit 0 first): half scale
        apply_reset(8, 4'b0111, 4);
        wait_valids(6, 6*512 + 200);
        chk("q3_pcm", pcm_last, 16384);

        // Reset while dcnt = 63, held across the would-be wrapping tick
        k = 0;
        while (tcnt != 63 && k < 1000) begin @(posedge clk); k++; end
        #1;
        chk("rst_sync", tcnt, 63);
        v0  = vcnt;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_pcm", pcm_o, 0);
        chk("midrst_valid", valid_o, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_valid", vcnt, v0);
        chk("midrst_pcm_after", pcm_o, 0);
        wait_valids(1, 64*8 + 50);
        chk("midrst_one_frame", vcnt, v0 + 1);

        // Minimum mclk period (clk/2): exact latency via the model, no dropped ticks
        apply_reset(2, 4'b1111, 1);
        v0 = vcnt;
        wait_valids(10, 10*128 + 100);
        chk("fast_frames", vcnt - v0, 10);
        chk("fast_rate", vlast - vprev, 128);
        chk("fast_pcm", pcm_last, 32767);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
